verif_cva6v_fifo_stream_reader: RTL and testbench

//  Pop-side reader for verif_cva6v_fifo_v3. It drains the FIFO through its empty/data/pop interface
//  and presents the entries as a valid/ready stream. A 2-entry output buffer (head + skid) gives

---
 rtl/verif_cva6v_fifo_stream_reader.sv | 81 ++++++++
 tb/tb_verif_cva6v_fifo_stream_reader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/verif_cva6v_fifo_stream_reader.sv
// Pop-side reader for a fall-through-free FIFO: drains it via empty/data/pop and re-presents
// the entries as a valid/ready stream through a two-entry head/skid buffer.
module verif_cva6v_fifo_stream_reader #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter type         dtype      = logic [DATA_WIDTH-1:0]
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       flush_i,
    input  logic       fifo_empty_i,
    input  dtype       fifo_data_i,
    output logic       fifo_pop_o,
    output logic       valid_o,
    input  logic       ready_i,
    output dtype       data_o,
    output logic [1:0] count_o,
    output logic       idle_o
);

    // State encoding doubles as the local entry count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state;
    dtype   head;
    dtype   skid;
    logic   deliver;

    // Pop depends only on local occupancy, never on the consumer's ready.
    assign fifo_pop_o = rst_ni && !fifo_empty_i && (state != FULL) && !flush_i;
    assign deliver    = valid_o && ready_i;
    assign valid_o    = (state != EMPTY);
    assign data_o     = head;
    assign count_o    = state;
    assign idle_o     = (state == EMPTY) && fifo_empty_i;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state <= EMPTY;
            head  <= '0;
            skid  <= '0;
        end else if (flush_i) begin
            state <= EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (fifo_pop_o) begin
                        state <= ONE;
                        head  <= fifo_data_i;
                    end
                end
                ONE: begin
                    if (fifo_pop_o && deliver) begin
                        head <= fifo_data_i;
                    end else if (fifo_pop_o) begin
                        state <= FULL;
                        skid  <= fifo_data_i;
                    end else if (deliver) begin
                        state <= EMPTY;
                    end
                end
                FULL: begin
                    if (deliver) begin
                        state <= ONE;
                        head  <= skid;
                    end
                end
                default: state <= EMPTY;
            endcase
        end
    end

    a_pop_nonempty : assert property (@(posedge clk_i) fifo_pop_o |-> !fifo_empty_i);
    a_count_range  : assert property (@(posedge clk_i) count_o <= 2'd2);
    a_hold_stable  : assert property (@(posedge clk_i) disable iff (!rst_ni)
        (rst_ni && valid_o && !ready_i && !flush_i) |=> ($stable(data_o) && valid_o));

endmodule

// File: tb/tb_verif_cva6v_fifo_stream_reader.sv
// Bench for the FIFO stream reader: a queue-based FIFO and local-buffer model drive
// directed scenarios followed by a long randomized run.
module tb_verif_cva6v_fifo_stream_reader;

    localparam int unsigned W = 32;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         flush_i;
    logic         fifo_empty_i;
    logic [W-1:0] fifo_data_i;
    logic         fifo_pop_o;
    logic         valid_o;
    logic         ready_i;
    logic [W-1:0] data_o;
    logic [1:0]   count_o;
    logic         idle_o;

    int checks   = 0;
    int failures = 0;
    int pushed   = 0;
    int dropped  = 0;

    logic [W-1:0] fq[$];
    logic [W-1:0] lb[$];
    logic [W-1:0] got[$];

    always #5 clk_i = ~clk_i;

    verif_cva6v_fifo_stream_reader #(.DATA_WIDTH(W)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .flush_i     (flush_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_data_i (fifo_data_i),
        .fifo_pop_o  (fifo_pop_o),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .data_o      (data_o),
        .count_o     (count_o),
        .idle_o      (idle_o)
    );

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [W-1:0] v);
        fq.push_back(v);
        pushed++;
    endtask

    // One clock cycle: drive, compare against the model, then advance the model.
    task automatic tick(input logic rst, input logic rdy, input logic fl);
        logic exp_pop;
        logic d;
        @(negedge clk_i);
        rst_ni       = rst;
        ready_i      = rdy;
        flush_i      = fl;
        fifo_empty_i = (fq.size() == 0);
        fifo_data_i  = (fq.size() != 0) ? fq[0] : '0;
        #1;
        exp_pop = rst && (fq.size() != 0) && (lb.size() < 2) && !fl;
        chk("valid", W'(valid_o), W'(lb.size() != 0));
        chk("count", W'(count_o), W'(lb.size()));
        chk("pop",   W'(fifo_pop_o), W'(exp_pop));
        chk("idle",  W'(idle_o), W'((lb.size() == 0) && (fq.size() == 0)));
        if (lb.size() != 0) chk("data", data_o, lb[0]);
        d = (lb.size() != 0) && rdy;
        if (!rst) begin
            dropped += lb.size();
            lb.delete();
        end else begin
            if (d) got.push_back(lb.pop_front());
            if (exp_pop) lb.push_back(fq.pop_front());
            if (fl) begin
                dropped += lb.size() + fq.size();
                lb.delete();
                fq.delete();
            end
        end
        @(posedge clk_i);
    endtask

    initial begin
        logic done;
        int   cyc;
        rst_ni       = 1'b0;
        ready_i      = 1'b0;
        flush_i      = 1'b0;
        fifo_empty_i = 1'b1;
        fifo_data_i  = '0;
        @(posedge clk_i);

        // Reset held with a non-empty FIFO: nothing may pop or go valid.
        for (int i = 0; i < 8; i++) push(W'(32'h11 + i));
        tick(1'b0, 1'b0, 1'b0);
        chk("rst_data", data_o, '0);
        tick(1'b0, 1'b0, 1'b0);
        chk("rst_data2", data_o, '0);

        // Back-to-back streaming.
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0);
        chk("stream_n", W'(got.size()), W'(8));
        for (int i = 0; i < 8 && i < got.size(); i++) chk("stream_ord", got[i], W'(32'h11 + i));
        got.delete();

        // Three-cycle consumer stall mid-stream.
        for (int i = 0; i < 8; i++) push(W'(32'h21 + i));
        tick(1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
        #1;
        chk("stall_full", W'(count_o), W'(2));
        chk("stall_nopop", W'(fifo_pop_o), W'(0));
        for (int i = 0; i < 10; i++) tick(1'b1, 1'b1, 1'b0);
        chk("stall_n", W'(got.size()), W'(8));
        for (int i = 0; i < 8 && i < got.size(); i++) chk("stall_ord", got[i], W'(32'h21 + i));
        got.delete();

        // Single entry into an empty FIFO.
        push(W'(32'hA5));
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
        chk("single_n", W'(got.size()), W'(1));
        if (got.size() != 0) chk("single_val", got[0], W'(32'hA5));
        #1;
        chk("single_idle", W'(idle_o), W'(1));
        got.delete();

        // Reset mid-stream discards buffered entries.
        push(W'(32'h31)); push(W'(32'h32)); push(W'(32'h33));
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0);
        tick(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
        chk("mrst_n", W'(got.size()), W'(1));
        if (got.size() != 0) chk("mrst_val", got[0], W'(32'h33));
        got.delete();

        // Flush while FULL.
        for (int i = 0; i < 4; i++) push(W'(32'h41 + i));
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b1);
        #1;
        chk("flush_cnt", W'(count_o), W'(0));
        chk("flush_vld", W'(valid_o), W'(0));
        push(W'(32'h77));
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1, 1'b0);
        chk("flush_n", W'(got.size()), W'(1));
        if (got.size() != 0) chk("flush_val", got[0], W'(32'h77));
        got.delete();

        // Randomized traffic.
        pushed  = 0;
        dropped = 0;
        done    = 1'b0;
        cyc     = 0;
        while (!done && cyc < 80000) begin
            if (pushed < 10000 && fq.size() < 8 && $urandom_range(0, 99) < 60) push($urandom);
            tick(1'b1, ($urandom_range(0, 99) < 70), ($urandom_range(0, 999) == 0));
            cyc++;
            done = (pushed >= 10000) && (fq.size() == 0) && (lb.size() == 0);
        end
        chk("rand_done", W'(done), W'(1));
        chk("rand_total", W'(got.size() + dropped), W'(pushed));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
